// File: rtl/mul_pkg.sv
// Shared types and constants for the result packing datapath.
// Holds the packing mode, the packer FSM states, the Frodo job size
// constants and the lane reduction helper used by lane_narrow.
package mul_pkg;

  // How 16-bit result lanes are laid into 64-bit BRAM words.
  typedef enum logic {
    PACK_WIDE   = 1'b0,
    PACK_NARROW = 1'b1
  } pack_mode_e;

  // Packer control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Frodo result matrix: 1344 words per job by default.
  localparam int FRODO_WORDS       = 1344;
  localparam int FRODO_NARROW_BITS = 1344 * 8;
  localparam int FRODO_WIDE_BITS   = 1344 * 16;

  // Geometry of one input beat.
  localparam int LANES      = 4;
  localparam int LANE_BITS  = 16;
  localparam int BYTE_BITS  = 8;

  // Reduce one 16-bit lane to a byte; with sat set, an overflowing lane
  // clips to all-ones instead of wrapping.
  function automatic logic [7:0] reduce_lane(input logic [15:0] lane, input bit sat);
    logic [7:0] r;
    if (sat && (|lane[15:8])) r = 8'hFF;
    else                      r = lane[7:0];
    return r;
  endfunction

endpackage

// File: rtl/lane_narrow.sv
// Squeezes four 16-bit result lanes into four bytes, lane0 into byte0.
// Build option: define RESULT_PACKER_SAT_EN to saturate lanes whose upper
// byte is nonzero to 8'hFF; otherwise each lane is truncated to lane[7:0].
import mul_pkg::*;

module lane_narrow (
  input  logic [63:0] lanes,
  output logic [31:0] bytes
);

`ifdef RESULT_PACKER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Per-lane reduction; the lane order is preserved byte for byte.
  always_comb begin
    bytes = '0;
    for (int i = 0; i < LANES; i++) begin
      bytes[i*BYTE_BITS +: BYTE_BITS] = reduce_lane(lanes[i*LANE_BITS +: LANE_BITS], SAT_EN);
    end
  end

endmodule

// File: rtl/result_packer.sv
// Packs 4x16-bit result beats into 64-bit BRAM words.
// WIDE mode writes every accepted beat unchanged; NARROW mode reduces each
// beat to 32 bits and writes one word per pair of beats, first beat low.
// Each job writes NUM_WORDS words starting at BASE_ADDR, stepping by
// ADDR_STEP, then pulses done. Build option RESULT_PACKER_SAT_EN (see
// lane_narrow) selects saturating instead of truncating narrowing.
import mul_pkg::*;

module result_packer #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          NUM_WORDS = FRODO_WORDS,
  parameter logic [31:0] ADDR_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        pack_mode,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic [31:0] bram_addr,
  output logic        bram_wen,
  output logic [63:0] bram_wdata,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] LAST_WORD = 32'(NUM_WORDS - 1);

  state_e      state;
  state_e      state_next;
  pack_mode_e  mode_q;
  logic [31:0] word_cnt;
  logic [31:0] half_q;
  logic        half_valid;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [31:0] addr_q;
  logic        done_q;

  logic        job_start;
  logic        accept;
  logic        word_done;
  logic        last_word;
  logic [31:0] narrow_bytes;

  lane_narrow u_lane_narrow (
    .lanes (in_data),
    .bytes (narrow_bytes)
  );

  // State register; abort and reset both land the FSM in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and handshake decode. Abort outranks start and beat
  // acceptance; in_ready is a function of state only.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    job_start  = 1'b0;
    accept     = 1'b0;
    word_done  = 1'b0;
    last_word  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          job_start  = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        accept    = in_valid && !abort;
        word_done = accept && ((mode_q == PACK_WIDE) || half_valid);
        last_word = word_done && (word_cnt == LAST_WORD);
        if (abort)          state_next = ST_IDLE;
        else if (last_word) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: job setup on start, half-word pairing, one-cycle write
  // strobe, address advance after each write and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= PACK_WIDE;
      word_cnt   <= '0;
      half_q     <= '0;
      half_valid <= 1'b0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      done_q     <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= (state == ST_DONE) && !abort;

      if (wen_q) addr_q <= addr_q + ADDR_STEP;

      if (job_start) begin
        mode_q     <= pack_mode_e'(pack_mode);
        word_cnt   <= '0;
        half_q     <= '0;
        half_valid <= 1'b0;
        addr_q     <= BASE_ADDR;
      end

      if (state == ST_RUN && abort) begin
        half_q     <= '0;
        half_valid <= 1'b0;
      end

      if (accept) begin
        if (mode_q == PACK_WIDE) begin
          wdata_q <= in_data;
          wen_q   <= 1'b1;
        end else if (!half_valid) begin
          half_q     <= narrow_bytes;
          half_valid <= 1'b1;
        end else begin
          wdata_q    <= {narrow_bytes, half_q};
          wen_q      <= 1'b1;
          half_valid <= 1'b0;
        end
        if (word_done) word_cnt <= word_cnt + 32'd1;
      end
    end
  end

  assign bram_wen   = wen_q;
  assign bram_wdata = wdata_q;
  assign bram_addr  = addr_q;
  assign done       = done_q;

endmodule
